// File: rtl/branch_sequencer_if.sv
// Control-transfer bus between the execute stage and the fetch sequencer:
// resolved branch requests flow in, the branch-register redirect flows out.
interface branch_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              br_valid;
  logic [1:0]        br_type;
  logic              br_cond;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] br_pc;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;

  modport master (
    output br_valid, br_type, br_cond, br_target, br_pc,
    input  branch_en, branch_addr
  );

  modport slave (
    input  br_valid, br_type, br_cond, br_target, br_pc,
    output branch_en, branch_addr
  );
endinterface

// File: rtl/branch_sequencer.sv
// MINI-RISC fetch sequencer: owns the PC, redirects on taken control transfers,
// squashes wrong-path fetches for a fixed count and keeps a small return stack.
module branch_sequencer #(
  parameter int          ADDR_W       = 11,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_req,
  branch_sequencer_if.slave bus,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              halted,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam logic [1:0] BR_JMP  = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_CALL = 2'b10;
  localparam logic [1:0] BR_RET  = 2'b11;

  localparam int FC_W   = $clog2(FLUSH_CYCLES + 1);
  localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  function automatic logic is_taken(input logic v, input logic [1:0] t,
                                    input logic c);
    return v && ((t != BR_COND) || c);
  endfunction

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic              branch_en_r;
  logic [ADDR_W-1:0] branch_addr_r;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [RAS_AW:0]   ras_sp;

  logic              accept;
  logic              taken;
  logic              is_call;
  logic              is_ret;
  logic              ras_empty;
  logic              ras_full;
  logic [RAS_AW:0]   ras_sp_m1;
  logic [ADDR_W-1:0] target;

  always_comb begin
    accept    = (state == RUN) && !stall;
    taken     = is_taken(bus.br_valid, bus.br_type, bus.br_cond);
    is_call   = (bus.br_type == BR_CALL);
    is_ret    = (bus.br_type == BR_RET);
    ras_empty = (ras_sp == '0);
    ras_full  = (ras_sp == (RAS_AW+1)'(RAS_DEPTH));
    ras_sp_m1 = ras_sp - (RAS_AW+1)'(1);
    target    = bus.br_target;
    // A RET only falls back to br_target when nothing was pushed to return to.
    if (is_ret && !ras_empty)
      target = ras[ras_sp_m1[RAS_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      flush_cnt     <= '0;
      branch_en_r   <= 1'b0;
      branch_addr_r <= '0;
      flush         <= 1'b0;
      halted        <= 1'b0;
      ras_sp        <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      branch_en_r <= 1'b0;
      unique case (state)
        RUN: begin
          if (accept) begin
            if (taken) begin
              pc            <= target;
              branch_addr_r <= target;
              branch_en_r   <= 1'b1;
              flush         <= 1'b1;
              flush_cnt     <= FC_W'(FLUSH_CYCLES - 1);
              state         <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
              if (is_call) begin
                if (ras_full) begin
                  ras_overflow <= 1'b1;
                end else begin
                  ras[ras_sp[RAS_AW-1:0]] <= addr_inc(bus.br_pc);
                  ras_sp                  <= ras_sp + (RAS_AW+1)'(1);
                end
              end else if (is_ret) begin
                if (ras_empty)
                  ras_underflow <= 1'b1;
                else
                  ras_sp <= ras_sp_m1;
              end
            end else if (halt_req) begin
              state  <= HALT;
              halted <= 1'b1;
              flush  <= 1'b0;
            end else begin
              pc    <= addr_inc(pc);
              flush <= 1'b0;
            end
          end
        end
        // Wrong-path requests arrive here, so br_valid and halt_req are ignored.
        FLUSH: begin
          if (!stall) begin
            pc <= addr_inc(pc);
            if (flush_cnt == '0) begin
              flush <= 1'b0;
              state <= RUN;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.branch_en   = branch_en_r;
  assign bus.branch_addr = branch_addr_r;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: stimulus pushes hand-computed expected
// outputs into a queue, a monitor compares them one cycle after each edge.
module tb_branch_sequencer;

  localparam logic [1:0] JMP = 2'b00;
  localparam logic [1:0] CND = 2'b01;
  localparam logic [1:0] CAL = 2'b10;
  localparam logic [1:0] RET = 2'b11;

  typedef struct packed {
    logic [10:0] pc;
    logic        en;
    logic [10:0] addr;
    logic        fl;
    logic        h;
    logic        ov;
    logic        un;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [10:0] pc;
  logic        flush, halted, ras_overflow, ras_underflow;

  branch_sequencer_if #(.ADDR_W(11)) bus ();

  branch_sequencer #(
    .ADDR_W(11), .FLUSH_CYCLES(2), .RAS_DEPTH(4), .RESET_PC(11'd0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .bus(bus),
    .pc(pc), .flush(flush), .halted(halted),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  obs_t  exp_q [$];
  string nm_q  [$];
  int    compared = 0;
  int    mismatched = 0;

  // Sticky expectations, updated by hand where the scenario changes them.
  logic [10:0] ea = '0;
  logic        eh = 1'b0, eov = 1'b0, eun = 1'b0;

  initial begin
    obs_t  e, g;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        g = '{pc: pc, en: bus.branch_en, addr: bus.branch_addr, fl: flush,
              h: halted, ov: ras_overflow, un: ras_underflow};
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL %s: got pc=%h en=%b addr=%h fl=%b h=%b ov=%b un=%b, want pc=%h en=%b addr=%h fl=%b h=%b ov=%b un=%b",
                   n, g.pc, g.en, g.addr, g.fl, g.h, g.ov, g.un,
                   e.pc, e.en, e.addr, e.fl, e.h, e.ov, e.un);
        end
      end
    end
  end

  task automatic cyc(input logic rs, st, hr, bv, input logic [1:0] bt,
                     input logic bc, input logic [10:0] tg, bp, ep,
                     input logic een, efl, input string nm);
    @(negedge clk);
    reset         = rs;
    stall         = st;
    halt_req      = hr;
    bus.br_valid  = bv;
    bus.br_type   = bt;
    bus.br_cond   = bc;
    bus.br_target = tg;
    bus.br_pc     = bp;
    exp_q.push_back('{pc: ep, en: een, addr: ea, fl: efl, h: eh, ov: eov, un: eun});
    nm_q.push_back(nm);
  endtask

  task automatic nop(input logic [10:0] ep, input logic efl, input string nm);
    cyc(0, 0, 0, 0, JMP, 0, 11'h0, 11'h0, ep, 0, efl, nm);
  endtask

  task automatic br(input logic [1:0] bt, input logic bc, input logic [10:0] tg,
                    bp, ep, input logic een, efl, input string nm);
    cyc(0, 0, 0, 1, bt, bc, tg, bp, ep, een, efl, nm);
  endtask

  initial begin
    logic [10:0] t;
    ea = '0; eh = 0; eov = 0; eun = 0;
    cyc(1, 0, 0, 0, JMP, 0, 11'h0, 11'h0, 11'h000, 0, 0, "reset");
    for (int i = 1; i <= 5; i++) nop(11'(i), 0, "free_run");

    // JMP at pc=5, branch during flush must be ignored
    ea = 11'h200;
    br(JMP, 0, 11'h200, 11'h005, 11'h200, 1, 1, "jmp_redirect");
    br(JMP, 0, 11'h300, 11'h200, 11'h201, 0, 1, "flush_ignores_br");
    nop(11'h202, 0, "flush_end");
    nop(11'h203, 0, "run_after_flush");

    // Conditional branches
    br(CND, 0, 11'h010, 11'h203, 11'h204, 0, 0, "cond_not_taken");
    ea = 11'h010;
    br(CND, 1, 11'h010, 11'h204, 11'h010, 1, 1, "cond_taken");
    nop(11'h011, 1, "cond_flush");
    nop(11'h012, 0, "cond_run");

    // CALL from 0x7FF returns to wrapped 0x000
    ea = 11'h040;
    br(CAL, 0, 11'h040, 11'h7FF, 11'h040, 1, 1, "call_7ff");
    nop(11'h041, 1, "call_flush");
    nop(11'h042, 0, "call_run");
    ea = 11'h000;
    br(RET, 0, 11'h123, 11'h042, 11'h000, 1, 1, "ret_wrap");
    nop(11'h001, 1, "ret_flush");
    nop(11'h002, 0, "ret_run");

    // Five nested CALLs overflow a 4-deep stack
    for (int k = 0; k < 5; k++) begin
      t  = 11'h300 + 11'(16 * k);
      ea = t;
      if (k == 4) eov = 1;
      br(CAL, 0, t, 11'h050 + 11'(k), t, 1, 1, "nested_call");
      nop(t + 11'd1, 1, "nested_flush");
      nop(t + 11'd2, 0, "nested_run");
    end
    // Stack holds 0x51..0x54; the dropped fifth push never returns
    for (int k = 3; k >= 0; k--) begin
      t  = 11'h051 + 11'(k);
      ea = t;
      br(RET, 0, 11'h7AA, 11'h100, t, 1, 1, "ret_pop");
      nop(t + 11'd1, 1, "ret_pop_flush");
      nop(t + 11'd2, 0, "ret_pop_run");
    end
    ea = 11'h033; eun = 1;
    br(RET, 0, 11'h033, 11'h100, 11'h033, 1, 1, "ret_underflow");
    nop(11'h034, 1, "underflow_flush");
    nop(11'h035, 0, "underflow_run");

    // Stall in RUN holds pc and the JMP; halt_req ignored while stalled
    cyc(0, 1, 1, 1, JMP, 0, 11'h0AA, 11'h035, 11'h035, 0, 0, "stall_run_halt_ign");
    cyc(0, 1, 0, 1, JMP, 0, 11'h0AA, 11'h035, 11'h035, 0, 0, "stall_run");
    cyc(0, 1, 0, 1, JMP, 0, 11'h0AA, 11'h035, 11'h035, 0, 0, "stall_run");
    ea = 11'h0AA;
    br(JMP, 0, 11'h0AA, 11'h035, 11'h0AA, 1, 1, "jmp_after_stall");
    cyc(0, 1, 0, 0, JMP, 0, 11'h0, 11'h0, 11'h0AA, 0, 1, "stall_flush");
    cyc(0, 1, 0, 0, JMP, 0, 11'h0, 11'h0, 11'h0AA, 0, 1, "stall_flush");
    nop(11'h0AB, 1, "flush_resume");
    nop(11'h0AC, 0, "flush_done");

    // JMP and halt together: branch first, halt on the next RUN cycle
    ea = 11'h150;
    cyc(0, 0, 1, 1, JMP, 0, 11'h150, 11'h0AC, 11'h150, 1, 1, "jmp_beats_halt");
    cyc(0, 0, 1, 0, JMP, 0, 11'h0, 11'h0, 11'h151, 0, 1, "halt_ign_flush");
    cyc(0, 0, 1, 0, JMP, 0, 11'h0, 11'h0, 11'h152, 0, 0, "halt_ign_flush_end");
    eh = 1;
    cyc(0, 0, 1, 0, JMP, 0, 11'h0, 11'h0, 11'h152, 0, 0, "halt_enter");
    cyc(0, 0, 0, 1, JMP, 0, 11'h400, 11'h0, 11'h152, 0, 0, "halt_hold");
    nop(11'h152, 0, "halt_hold");

    // Reset out of HALT clears everything
    ea = '0; eh = 0; eov = 0; eun = 0;
    cyc(1, 0, 0, 0, JMP, 0, 11'h0, 11'h0, 11'h000, 0, 0, "reset_from_halt");
    nop(11'h001, 0, "run_after_reset");

    // Reset in the middle of a flush
    ea = 11'h077;
    br(JMP, 0, 11'h077, 11'h001, 11'h077, 1, 1, "jmp_pre_reset");
    ea = '0;
    cyc(1, 0, 0, 0, JMP, 0, 11'h0, 11'h0, 11'h000, 0, 0, "reset_mid_flush");
    nop(11'h001, 0, "run_after_reset2");

    @(negedge clk);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Fetch-address sequencer and branch controller for the MINI-RISC pipeline. It owns the program counter, accepts resolved control-transfer requests from the execute stage, and drives the load-enable and address of the branch register. It squashes wrong-path instructions with a fixed-length flush and keeps a small return-address stack for CALL/RET. It also provides a halt state.

## Interface
- ADDR_W, 11, width of all instruction addresses
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect (≥1)
- RAS_DEPTH, 4, return-address stack entries (power of two)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline stall; freezes the sequencer
- br_valid  in  1  EX presents a resolved control-transfer instruction this cycle
- br_type  in  2  00 JMP, 01 conditional branch, 10 CALL, 11 RET
- br_cond  in  1  condition outcome; used only when br_type=01
- br_target  in  ADDR_W  target for JMP/COND/CALL; fallback target for RET
- br_pc  in  ADDR_W  address of the branch instruction
- halt_req  in  1  request to stop fetching
- pc  out  ADDR_W  current fetch address
- branch_en  out  1  one-cycle load pulse to the branch register
- branch_addr  out  ADDR_W  redirect address accompanying branch_en
- flush  out  1  squash the IF/ID contents
- halted  out  1  sequencer is in HALT
- ras_overflow  out  1  sticky; a CALL was issued while the RAS was full
- ras_underflow  out  1  sticky; a RET was issued while the RAS was empty

## Operation
- FSM states: RUN, FLUSH, HALT. All outputs are registered.
- A branch is **taken** when br_valid=1 and any of:
  - br_type is JMP, CALL or RET
  - br_type is COND and br_cond=1
- A not-taken COND has no effect: no pulse, no flush.

RUN, stall=0:
- Taken branch:
  - pc and branch_addr load the target; branch_en=1 for one cycle; flush=1.
  - Flush counter loads FLUSH_CYCLES−1; next state is FLUSH, or RUN if FLUSH_CYCLES=1.
- No taken branch: pc <= pc+1, modulo 2^ADDR_W (2047 → 0).
- halt_req with no taken branch: next state HALT, halted=1, pc frozen.
- Taken branch and halt_req in the same cycle: the branch wins. Halt is honoured on a later RUN cycle if halt_req is still high.

RUN, stall=1:
- pc is held and br_valid is ignored. EX must hold its request until the sequencer is unstalled.
- halt_req is also ignored.

FLUSH:
- pc increments each unstalled cycle and flush stays 1.
- br_valid and halt_req are ignored, since they come from squashed instructions.
- The counter decrements only when stall=0. At 0 with stall=0, flush drops and the state returns to RUN on the next cycle.

HALT:
- pc is held, halted=1, and all inputs are ignored. Only reset exits.

Return-address stack (RAS):
- CALL pushes br_pc+1 (wraps modulo 2^ADDR_W).
- CALL on a full RAS: the push is dropped, ras_overflow is set, and the jump still happens.
- RET target is the top of the RAS, which is then popped; br_target is ignored.
- RET on an empty RAS: target is br_target and ras_underflow is set.
- RAS only changes on an accepted taken CALL/RET.

## Timing
- Reset (clock edge with reset=1) gives:
  - pc=RESET_PC, branch_addr=0, branch_en=0, flush=0, halted=0
  - ras_overflow=0, ras_underflow=0
  - RAS empty, state RUN
- Reset overrides every state, including mid-FLUSH and HALT.
- Redirect latency: branch accepted in cycle N ⇒ in cycle N+1 pc=target, branch_en=1 and flush=1. In cycle N+2, pc=target+1.
- flush is high for exactly FLUSH_CYCLES unstalled cycles starting at N+1. Stalled cycles extend it.
- branch_en is never high in two consecutive cycles.
- branch_addr holds its last value when branch_en=0.
- Sticky flags clear only on reset.

## Test plan
- Reset then 5 free-running cycles → pc = 0,1,2,3,4. branch_en=0, flush=0 throughout.
- At pc=5, JMP with br_target=0x200 → next cycle pc=0x200, branch_en=1, branch_addr=0x200. flush=1 for 2 cycles, then pc=0x202 in RUN. A br_valid driven during FLUSH is ignored.
- COND with br_cond=0 → pc just increments, no pulse, no flush. The same with br_cond=1 and target 0x10 → redirect to 0x10.
- CALL at br_pc=0x7FF with target 0x40 → pc=0x40. A later RET → pc=0x000 (wrapped return address) and the RAS is empty. Five nested CALLs → ras_overflow=1. RET on an empty RAS with br_target=0x33 → pc=0x33 and ras_underflow=1.
- stall=1 for 3 cycles during RUN → pc holds and a held JMP is accepted on the first unstalled cycle. Stall during FLUSH lengthens flush to 2+stall cycles.
- halt_req in the same cycle as a taken JMP → redirect first, then HALT with pc frozen. Reset during HALT → pc=0, halted=0.
